dense_grad_input: RTL

- Sequential backward-pass companion to the combinational dense layer.
- Computes the input gradient dx[i] = sum_j W(j,i) * dy[j] for i = 0..INPUT_SIZE-1. This is the transposed product over the same weight store and layout the forward layer uses.
- Consumes the flattened output gradient, reads weights through a 1-cycle-latency memory port, and streams dx elements out over a valid/ready interface, one per element, in index order.

---
 rtl/dense_grad_input.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/dense_grad_input.sv
// Backward pass of the dense layer: dx[i] = sum_j W(j,i) * dy[j], one dx element at a time,
// reading weights through a 1-cycle-latency port and streaming results over valid/ready.
module dense_grad_input #(
  parameter int unsigned INPUT_SIZE  = 4096,
  parameter int unsigned OUTPUT_SIZE = 128,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ACC_WIDTH   = 24,
  parameter int unsigned SHIFT       = 0,
  localparam int unsigned AddrW = $clog2(INPUT_SIZE * OUTPUT_SIZE),
  localparam int unsigned IdxW  = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1,
  localparam int unsigned JW    = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              start_i,
  input  logic [DATA_WIDTH*OUTPUT_SIZE-1:0] grad_out_i,
  output logic                              w_rd_en_o,
  output logic [AddrW-1:0]                  w_addr_o,
  input  logic [DATA_WIDTH-1:0]             w_rdata_i,
  output logic [DATA_WIDTH-1:0]             dx_data_o,
  output logic [IdxW-1:0]                   dx_index_o,
  output logic                              dx_valid_o,
  input  logic                              dx_ready_i,
  output logic                              busy_o,
  output logic                              done_o
);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StOut} state_e;

  localparam logic [JW-1:0]   JLast = JW'(OUTPUT_SIZE - 1);
  localparam logic [IdxW-1:0] ILast = IdxW'(INPUT_SIZE - 1);
  localparam logic signed [ACC_WIDTH-1:0] SatMax = ACC_WIDTH'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] SatMin = ~SatMax;

  state_e                        state_q;
  logic [JW-1:0]                 j_q;
  logic [IdxW-1:0]               i_q;
  logic signed [ACC_WIDTH-1:0]   acc_q;
  logic [DATA_WIDTH-1:0]         dy_q [OUTPUT_SIZE];
  logic                          w_rd_en_q;
  logic [AddrW-1:0]              w_addr_q;
  logic [DATA_WIDTH-1:0]         dx_data_q;
  logic [IdxW-1:0]               dx_index_q;
  logic                          dx_valid_q;
  logic                          busy_q;
  logic                          done_q;

  logic                          data_vld;
  logic [JW-1:0]                 data_j;
  logic signed [2*DATA_WIDTH-1:0] w_ext;
  logic signed [2*DATA_WIDTH-1:0] dy_ext;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]   prod_ext;
  logic signed [ACC_WIDTH-1:0]   acc_sum;
  logic signed [ACC_WIDTH-1:0]   shifted;
  logic [DATA_WIDTH-1:0]         sat_data;
  logic [AddrW-1:0]              fetch_addr;

  // w_rdata_i belongs to the read issued one cycle earlier, i.e. to j_q-1 (or j_q in drain).
  always_comb begin
    data_vld   = (state_q == StDrain) || ((state_q == StFetch) && (j_q != '0));
    data_j     = (state_q == StDrain) ? j_q : j_q - JW'(1);
    w_ext      = {{DATA_WIDTH{w_rdata_i[DATA_WIDTH-1]}}, w_rdata_i};
    dy_ext     = {{DATA_WIDTH{dy_q[data_j][DATA_WIDTH-1]}}, dy_q[data_j]};
    prod       = w_ext * dy_ext;
    prod_ext   = ACC_WIDTH'(prod);
    acc_sum    = acc_q + prod_ext;
    shifted    = acc_sum >>> SHIFT;
    sat_data   = shifted[DATA_WIDTH-1:0];
    if (shifted > SatMax) begin
      sat_data = SatMax[DATA_WIDTH-1:0];
    end else if (shifted < SatMin) begin
      sat_data = SatMin[DATA_WIDTH-1:0];
    end
    fetch_addr = AddrW'(j_q + JW'(1)) * AddrW'(INPUT_SIZE) + AddrW'(i_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      j_q        <= '0;
      i_q        <= '0;
      acc_q      <= '0;
      for (int k = 0; k < OUTPUT_SIZE; k++) dy_q[k] <= '0;
      w_rd_en_q  <= 1'b0;
      w_addr_q   <= '0;
      dx_data_q  <= '0;
      dx_index_q <= '0;
      dx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            for (int k = 0; k < OUTPUT_SIZE; k++) begin
              dy_q[k] <= grad_out_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
            i_q       <= '0;
            j_q       <= '0;
            acc_q     <= '0;
            w_rd_en_q <= 1'b1;
            w_addr_q  <= '0;
            busy_q    <= 1'b1;
            state_q   <= StFetch;
          end
        end
        StFetch: begin
          if (data_vld) acc_q <= acc_sum;
          if (j_q == JLast) begin
            w_rd_en_q <= 1'b0;
            w_addr_q  <= '0;
            state_q   <= StDrain;
          end else begin
            j_q      <= j_q + JW'(1);
            w_addr_q <= fetch_addr;
          end
        end
        StDrain: begin
          acc_q      <= acc_sum;
          dx_valid_q <= 1'b1;
          dx_data_q  <= sat_data;
          dx_index_q <= i_q;
          state_q    <= StOut;
        end
        StOut: begin
          if (dx_ready_i) begin
            dx_valid_q <= 1'b0;
            if (i_q == ILast) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= StIdle;
            end else begin
              i_q       <= i_q + IdxW'(1);
              j_q       <= '0;
              acc_q     <= '0;
              w_rd_en_q <= 1'b1;
              w_addr_q  <= AddrW'(i_q) + AddrW'(1);
              state_q   <= StFetch;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign w_rd_en_o  = w_rd_en_q;
  assign w_addr_o   = w_addr_q;
  assign dx_data_o  = dx_data_q;
  assign dx_index_o = dx_index_q;
  assign dx_valid_o = dx_valid_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule
